multicycle_control: RTL and testbench

//  Moore-style main controller sequencing the multicycle MIPS datapath (PC, memory, IR, register file, ALU, muxes).

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore main controller for the multicycle MIPS datapath: sequences fetch, decode and
// per-class execute states, stretching memory-read states by MEM_LAT wait cycles.
module multicycle_control #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       Branch,
    output logic       PCWrite,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [2:0] LAT     = MEM_LAT[2:0];

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_wait;
    logic       r_ok;
    logic [3:0] r_alu;
    logic       mem_write_raw, ir_write_raw, reg_write_raw;
    logic       pc_write_raw, branch_raw, retire_raw;

    assign last_wait = (cnt_q == LAT);

    always_comb begin
        r_ok  = 1'b1;
        r_alu = 4'b0000;
        case (funct)
            6'b100000: r_alu = 4'b0000;
            6'b100010: r_alu = 4'b0001;
            6'b100100: r_alu = 4'b1000;
            6'b100101: r_alu = 4'b1001;
            6'b100110: r_alu = 4'b1010;
            6'b100111: r_alu = 4'b1011;
            default:   r_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = 4'b0000;
        PCSrc         = 2'b00;
        illegal       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        retire_raw    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                if (last_wait) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = r_ok ? S_EXECUTE : S_HALT;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
                if (last_wait) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = r_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 4'b0001;
                PCSrc      = 2'b01;
                branch_raw = 1'b1;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                PCSrc        = 2'b10;
                pc_write_raw = 1'b1;
                retire_raw   = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT:  illegal = 1'b1;
            default: state_d = S_HALT;
        endcase
    end

    // Wait counter restarts on entry to a memory-read state and saturates at 7.
    always_comb begin
        if ((state_d == S_FETCH || state_d == S_MEMREAD) && state_d != state_q)
            cnt_d = 3'd0;
        else if (cnt_q != 3'd7)
            cnt_d = cnt_q + 3'd1;
        else
            cnt_d = cnt_q;
    end

    // Enables are gated by rst_n so no write escapes while reset is held.
    assign MemWrite = mem_write_raw & rst_n;
    assign IRWrite  = ir_write_raw  & rst_n;
    assign RegWrite = reg_write_raw & rst_n;
    assign PCWrite  = pc_write_raw  & rst_n;
    assign Branch   = branch_raw    & rst_n;
    assign retire   = retire_raw    & rst_n;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences built from the
// instruction-class rules, compared cycle by cycle on MEM_LAT=1 and MEM_LAT=0 instances.
module tb_multicycle_control;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic [1:0] pc_src;
        logic       branch;
        logic       pc_write;
        logic       retire;
        logic       illegal;
        logic [3:0] st;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst0_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;

    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl, state;
    logic       Branch, PCWrite, retire, illegal;

    logic       IorD_0, MemWrite_0, IRWrite_0, RegDst_0, MemtoReg_0, RegWrite_0, ALUSrcA_0;
    logic [1:0] ALUSrcB_0, PCSrc_0;
    logic [3:0] ALUControl_0, state_0;
    logic       Branch_0, PCWrite_0, retire_0, illegal_0;

    logic [22:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          halt_len = 100;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .Branch(Branch), .PCWrite(PCWrite),
        .retire(retire), .illegal(illegal), .state(state)
    );

    multicycle_control #(.MEM_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .opcode(opcode), .funct(funct),
        .IorD(IorD_0), .MemWrite(MemWrite_0), .IRWrite(IRWrite_0), .RegDst(RegDst_0),
        .MemtoReg(MemtoReg_0), .RegWrite(RegWrite_0), .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0),
        .ALUControl(ALUControl_0), .PCSrc(PCSrc_0), .Branch(Branch_0), .PCWrite(PCWrite_0),
        .retire(retire_0), .illegal(illegal_0), .state(state_0)
    );

    function automatic ctl_t obs(input int which);
        ctl_t v;
        if (which == 0)
            v = '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                  ALUControl, PCSrc, Branch, PCWrite, retire, illegal, state};
        else
            v = '{IorD_0, MemWrite_0, IRWrite_0, RegDst_0, MemtoReg_0, RegWrite_0, ALUSrcA_0,
                  ALUSrcB_0, ALUControl_0, PCSrc_0, Branch_0, PCWrite_0, retire_0, illegal_0,
                  state_0};
        return v;
    endfunction

    function automatic ctl_t blank(input logic [3:0] s);
        ctl_t v = '0;
        v.st = s;
        return v;
    endfunction

    // Reset view: FETCH selects with every enable low.
    function automatic ctl_t reset_vec();
        ctl_t v = blank(4'd0);
        v.alu_src_b = 2'b01;
        return v;
    endfunction

    function automatic logic r_legal(input logic [5:0] fn, output logic [3:0] alu);
        alu = 4'b0000;
        case (fn)
            6'b100000: alu = 4'b0000;
            6'b100010: alu = 4'b0001;
            6'b100100: alu = 4'b1000;
            6'b100101: alu = 4'b1001;
            6'b100110: alu = 4'b1010;
            6'b100111: alu = 4'b1011;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic int cycles_of(input logic [5:0] op, input logic [5:0] fn, input int ml);
        logic [3:0] a;
        case (op)
            OP_LW:          return 2 * ml + 5;
            OP_SW, OP_ADDI: return ml + 4;
            OP_R:           return r_legal(fn, a) ? ml + 4 : 0;
            OP_BEQ, OP_J:   return ml + 3;
            default:        return 0;
        endcase
    endfunction

    // Expected per-cycle outputs of one instruction, from its class.
    task automatic model_push(input logic [5:0] op, input logic [5:0] fn, input int ml);
        ctl_t       v;
        logic [3:0] alu;
        logic       ok;
        for (int i = 0; i <= ml; i++) begin
            v = reset_vec();
            v.ir_write = (i == ml);
            v.pc_write = (i == ml);
            exp_q.push_back(v);
        end
        v = blank(4'd1); v.alu_src_b = 2'b11; exp_q.push_back(v);
        ok = r_legal(fn, alu);
        if (op == OP_LW || op == OP_SW) begin
            v = blank(4'd2); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; exp_q.push_back(v);
        end
        if (op == OP_LW) begin
            for (int i = 0; i <= ml; i++) begin
                v = blank(4'd3); v.iord = 1'b1; exp_q.push_back(v);
            end
            v = blank(4'd4); v.mem_to_reg = 1'b1; v.reg_write = 1'b1; v.retire = 1'b1;
            exp_q.push_back(v);
        end else if (op == OP_SW) begin
            v = blank(4'd5); v.iord = 1'b1; v.mem_write = 1'b1; v.retire = 1'b1;
            exp_q.push_back(v);
        end else if (op == OP_R && ok) begin
            v = blank(4'd6); v.alu_src_a = 1'b1; v.alu_ctl = alu; exp_q.push_back(v);
            v = blank(4'd7); v.reg_dst = 1'b1; v.reg_write = 1'b1; v.retire = 1'b1;
            exp_q.push_back(v);
        end else if (op == OP_BEQ) begin
            v = blank(4'd8); v.alu_src_a = 1'b1; v.alu_ctl = 4'b0001; v.pc_src = 2'b01;
            v.branch = 1'b1; v.retire = 1'b1; exp_q.push_back(v);
        end else if (op == OP_ADDI) begin
            v = blank(4'd9); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; exp_q.push_back(v);
            v = blank(4'd10); v.reg_write = 1'b1; v.retire = 1'b1; exp_q.push_back(v);
        end else if (op == OP_J) begin
            v = blank(4'd11); v.pc_src = 2'b10; v.pc_write = 1'b1; v.retire = 1'b1;
            exp_q.push_back(v);
        end else begin
            for (int i = 0; i < halt_len; i++) begin
                v = blank(4'd15); v.illegal = 1'b1; exp_q.push_back(v);
            end
        end
    endtask

    // Called in the first FETCH cycle, #1 after the clock edge.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int which);
        ctl_t got, exp;
        int   cyc, retires, ret_at, want;
        opcode = op;
        funct  = fn;
        #1;
        exp_q.delete();
        model_push(op, fn, (which == 0) ? 1 : 0);
        cyc = 0; retires = 0; ret_at = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = obs(which);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got=%h expected=%h", name, cyc, got, exp);
            end
            cyc++;
            if (got.retire === 1'b1) begin
                retires++;
                ret_at = cyc;
            end
            @(posedge clk);
            #1;
        end
        want = cycles_of(op, fn, (which == 0) ? 1 : 0);
        checks++;
        if (want != 0) begin
            if (retires != 1 || ret_at != want) begin
                errors++;
                $display("FAIL %s_length: retires=%0d at cycle %0d, expected 1 at cycle %0d",
                         name, retires, ret_at, want);
            end
        end else if (retires != 0) begin
            errors++;
            $display("FAIL %s_halt_retire: retires=%0d, expected 0", name, retires);
        end
    endtask

    task automatic pulse_reset();
        ctl_t got;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        got = obs(0);
        checks++;
        if (got !== reset_vec()) begin
            errors++;
            $display("FAIL reset_pulse: got=%h expected=%h", got, reset_vec());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ctl_t got;
        rst_n = 1'b0;
        rst0_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = obs(0);
        checks++;
        if (got !== reset_vec()) begin
            errors++;
            $display("FAIL reset_lat1: got=%h expected=%h", got, reset_vec());
        end
        got = obs(1);
        checks++;
        if (got !== reset_vec()) begin
            errors++;
            $display("FAIL reset_lat0: got=%h expected=%h", got, reset_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_abort_memread();
        ctl_t got;
        opcode = OP_LW;
        funct  = 6'd0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("FAIL abort_setup_state: got=%0d expected=3", state);
        end
        #2 rst_n = 1'b0;
        #1;
        got = obs(0);
        checks++;
        if (got !== reset_vec()) begin
            errors++;
            $display("FAIL abort_async: got=%h expected=%h", got, reset_vec());
        end
        @(posedge clk);
        #1;
        got = obs(0);
        checks++;
        if (got !== reset_vec()) begin
            errors++;
            $display("FAIL abort_held: got=%h expected=%h", got, reset_vec());
        end
        rst_n = 1'b1;
        run_instr("lw_after_abort", OP_LW, 6'd0, 0);
    endtask

    task automatic test_illegal();
        halt_len = 100;
        run_instr("illegal_opcode", 6'b111111, 6'b100000, 0);
        pulse_reset();
        run_instr("illegal_funct", OP_R, 6'b001100, 0);
        pulse_reset();
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111};
        logic [5:0] op, fn;
        logic [3:0] a;
        halt_len = 8;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr("random", op, fn, 0);
            if (cycles_of(op, fn, 1) == 0 || (op == OP_R && !r_legal(fn, a)))
                pulse_reset();
        end
    endtask

    task automatic test_mem_lat0();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst0_n = 1'b1;
        run_instr("lw_lat0", OP_LW, 6'd0, 1);
        run_instr("sw_lat0", OP_SW, 6'd0, 1);
        rst0_n = 1'b0;
    endtask

    initial begin
        test_reset();
        run_instr("lw", OP_LW, 6'd0, 0);
        run_instr("r_xor", OP_R, 6'b100110, 0);
        run_instr("beq", OP_BEQ, 6'b101010, 0);
        run_instr("sw", OP_SW, 6'd0, 0);
        run_instr("j", OP_J, 6'd0, 0);
        run_instr("addi", OP_ADDI, 6'd0, 0);
        run_instr("r_nor", OP_R, 6'b100111, 0);
        test_abort_memread();
        test_illegal();
        test_random();
        test_mem_lat0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
